// File: rtl/count_disp_pkg.sv
// Shared types and constants for the count display block: FSM states, widths, 7-segment decode.
// Pure definitions, no latency.
// No flow control.
package count_disp_pkg;

    localparam int CNT_W = 8;
    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Latency: start cycle + 8 cycles; done pulses in the 8th cycle with bcd valid alongside it.
// No backpressure: start while busy restarts the conversion.
module bin2bcd_seq
    import count_disp_pkg::*;
(
    input  logic             CLK,
    input  logic             Rd,
    input  logic             start,
    input  logic [CNT_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int SH_W = BCD_W + CNT_W;

    logic [SH_W-1:0] sh_q, sh_d, sh_step;
    logic [2:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;

    // Upper BCD_W bits hold the BCD digits, lower CNT_W bits the remaining binary.
    function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] t;
        t = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (t[CNT_W + 4*i +: 4] >= 4'd5) begin
                t[CNT_W + 4*i +: 4] = t[CNT_W + 4*i +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

    always_comb begin
        sh_step = dabble(sh_q);
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start) begin
            sh_d   = {{BCD_W{1'b0}}, bin};
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d  = sh_step;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Rd) begin
            sh_q   <= '0;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // The eighth step is presented combinationally so the caller can latch it on the same edge.
    assign done = busy_q && (cnt_q == 3'd7);
    assign bcd  = sh_step[SH_W-1 -: BCD_W];

endmodule

// File: rtl/count_display_scan.sv
// Samples an asynchronous 8-bit count, converts it to BCD and scans it onto a 3-digit 7-segment display.
// Latency: tick to bcd_upd 10 cycles when stable, +1 per unstable sample; overflow flag 3 cycles after carry.
// No backpressure: results are simply overwritten by the next accepted sample.
module count_display_scan
    import count_disp_pkg::*;
#(
    parameter int SAMPLE_DIV   = 1000,
    parameter int SCAN_DIV     = 500,
    parameter int STABLE_TRIES = 15
) (
    input  logic             CLK,
    input  logic             Rd,
    input  logic [CNT_W-1:0] Q_in,
    input  logic             Cout_in,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_upd,
    output logic             ovf,
    output logic             err,
    output logic [2:0]       dig,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam logic [15:0] SMP_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  TRIES_LIM = 8'(STABLE_TRIES);

    logic [CNT_W-1:0] q_meta_q, q_s_q, q_prev_q;
    logic             c_meta_q, c_s_q, c_prev_q;
    logic [15:0]      smp_cnt_q, smp_cnt_d;
    logic [15:0]      scan_cnt_q, scan_cnt_d;
    logic [2:0]       dig_q, dig_d;
    state_t           state_q, state_d;
    logic [7:0]       tries_q, tries_d, tries_inc;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             smp_tick, scan_wrap;
    logic             conv_start, conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [3:0]       nib;

    bin2bcd_seq u_conv (
        .CLK   (CLK),
        .Rd    (Rd),
        .start (conv_start),
        .bin   (q_s_q),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign smp_tick   = (smp_cnt_q == SMP_LAST);
    assign smp_cnt_d  = smp_tick ? 16'd0 : smp_cnt_q + 16'd1;
    assign scan_wrap  = (scan_cnt_q == SCAN_LAST);
    assign scan_cnt_d = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;
    assign dig_d      = scan_wrap ? {dig_q[1:0], dig_q[2]} : dig_q;
    assign ovf_d      = ovf_q | (c_s_q & ~c_prev_q);

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        err_d      = err_q;
        bcd_d      = bcd_q;
        conv_start = 1'b0;
        tries_inc  = tries_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (smp_tick) begin
                    state_d = SAMPLE;
                    tries_d = 8'd0;
                end
            end
            SAMPLE: begin
                // Two equal consecutive synchronised samples mean the ripple has settled.
                if (q_s_q == q_prev_q) begin
                    conv_start = 1'b1;
                    state_d    = CONVERT;
                end else begin
                    tries_d = tries_inc;
                    if (tries_inc == TRIES_LIM) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    bcd_d   = conv_bcd;
                    state_d = UPDATE;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Rd) begin
            q_meta_q   <= '0;
            q_s_q      <= '0;
            q_prev_q   <= '0;
            c_meta_q   <= 1'b0;
            c_s_q      <= 1'b0;
            c_prev_q   <= 1'b0;
            smp_cnt_q  <= 16'd0;
            scan_cnt_q <= 16'd0;
            dig_q      <= 3'b001;
            state_q    <= IDLE;
            tries_q    <= 8'd0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            q_meta_q   <= Q_in;
            q_s_q      <= q_meta_q;
            q_prev_q   <= q_s_q;
            c_meta_q   <= Cout_in;
            c_s_q      <= c_meta_q;
            c_prev_q   <= c_s_q;
            smp_cnt_q  <= smp_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            state_q    <= state_d;
            tries_q    <= tries_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    // Digit mux reads bcd_q directly so a fresh result shows in the cycle it lands.
    always_comb begin
        nib = bcd_q[3:0];
        if (dig_q[1]) begin
            nib = bcd_q[7:4];
        end else if (dig_q[2]) begin
            nib = bcd_q[11:8];
        end
    end

    assign seg     = seg_decode(nib);
    assign bcd     = bcd_q;
    assign bcd_upd = (state_q == UPDATE);
    assign ovf     = ovf_q;
    assign err     = err_q;
    assign dp      = ovf_q;
    assign dig     = dig_q;

endmodule
